bin_to_bcd_stream: RTL and testbench
====================================

# bin_to_bcd_stream

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It is the handshaked, signed-capable successor to the load/pulse-driven binary-to-decimal counter. It sits between binary arithmetic sources and decimal display/formatting logic. It adds valid/ready flow control on both sides, an optional signed mode, a sticky overflow flag and a significant-digit count.

## Interface
- `BIN_WIDTH`, default 32: input binary width, must be ≥ 1.
- `NUM_DIGITS`, default 10: number of output BCD digits, must be ≥ 1.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: `in_data` and `in_signed` are presented.
- `in_ready` out 1: converter idle; a transfer occurs on `in_valid && in_ready`.
- `in_data` in `BIN_WIDTH`: binary operand.
- `in_signed` in 1: 1 = interpret `in_data` as two's complement; sampled at transfer.
- `out_valid` out 1: result registers hold a completed conversion.
- `out_ready` in 1: consumer accepts the result on `out_valid && out_ready`.
- `bcd` out `[NUM_DIGITS-1:0][3:0]`: digits, index 0 = least significant.
- `neg` out 1: result is negative (signed mode only).
- `ovf` out 1: magnitude ≥ 10^NUM_DIGITS; `bcd` then holds magnitude mod 10^NUM_DIGITS.
- `digit_count` out `$clog2(NUM_DIGITS+1)`: index of the highest non-zero digit + 1, minimum 1.

## Operation
- The FSM has three states: IDLE, CONV and DONE.
- In IDLE, `in_ready` = 1. On transfer:
  - shift register ← magnitude: `in_data` when `in_signed`=0 or MSB=0, else `-in_data` (two's complement).
  - `neg` ← `in_signed & in_data[MSB]`.
  - `bcd` ← 0, `ovf` ← 0, bit counter ← `BIN_WIDTH`.
  - Next state is CONV.
- In CONV, each cycle performs one step:
  - every digit ≥ 5 gets +3;
  - the whole {`bcd`, shift register} shifts left 1;
  - the bit leaving digit NUM_DIGITS-1 bit 3 is ORed into `ovf` (sticky);
  - the counter decrements.
- The step with counter == 1 is the last; its edge moves the FSM to DONE.
- In DONE, `out_valid` = 1. `bcd`, `neg`, `ovf` and `digit_count` stay stable until `out_valid && out_ready`; that edge moves the FSM to IDLE.
- `in_valid` outside IDLE is ignored (`in_ready` = 0). The source must hold its data.
- The most negative input (e.g. 32'h80000000) yields magnitude 2^(BIN_WIDTH-1), which is exact, with `neg` = 1.
- `digit_count` is combinational from `bcd` and meaningful only while `out_valid` = 1. Zero gives 1.
- Overflow does not stop conversion. The low digits remain correct modulo 10^NUM_DIGITS.
- Degenerate cases:
  - BIN_WIDTH = 1: one CONV cycle.
  - NUM_DIGITS = 1: `ovf` is set for any magnitude ≥ 10.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `bcd` 0, `neg` 0, `ovf` 0, `digit_count` 1.
- Timeline for a transfer at edge 0:
  - edges 1..BIN_WIDTH perform the steps;
  - `out_valid` rises after edge BIN_WIDTH, so latency is BIN_WIDTH cycles;
  - with `out_ready` held 1, the result is consumed at edge BIN_WIDTH+1;
  - `in_ready` is 1 again after edge BIN_WIDTH+1.
- Maximum throughput is one conversion per BIN_WIDTH+2 cycles.
- `rst` asserted in any state, including mid-CONV or DONE, returns to reset values at the next edge. The in-flight result is discarded and never presented.
- `in_ready` and `out_valid` are never 1 simultaneously.
- All outputs are registered except `in_ready` (state decode) and `digit_count` (from registered `bcd`).

## Structure
- Package `bcd_pkg`:
  - state enum `conv_state_t` {IDLE, CONV, DONE};
  - `BCD_DIGIT_W` = 4;
  - function `count_w(n)` = `$clog2(n+1)`.
- Sub-module `bcd_digit_step`: one digit. Inputs: digit and shift-in bit. Outputs: next digit and shift-out bit (adjust ≥5 by +3, then shift). It is instantiated NUM_DIGITS times in a generate chain; the last shift-out feeds `ovf`.
- The top level holds the FSM, bit counter, magnitude/negation logic, output registers and `digit_count` priority encoder.

## Test plan
- Unsigned 1234567890, BIN_WIDTH=32, NUM_DIGITS=10, `out_ready`=1 → `bcd` = 1,2,3,4,5,6,7,8,9,0, `ovf` 0, `digit_count` 10, `out_valid` exactly 32 cycles after transfer.
- Unsigned 32'hFFFFFFFF:
  - NUM_DIGITS=10 → 4294967295, `ovf` 0;
  - NUM_DIGITS=3 instance → digits 2,9,5, `ovf` 1.
- Signed mode:
  - 32'h80000000 → `neg` 1, 2147483648;
  - 32'hFFFFFFFF → `neg` 1, digits …0001, `digit_count` 1;
  - the same word unsigned → `neg` 0.
- Input 0 → all digits 0, `ovf` 0, `neg` 0, `digit_count` 1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while pulsing `in_valid` with new data → outputs stable, `in_ready` 0, new data not accepted. Raise `out_ready` → IDLE next edge; the second operand then converts correctly.
- Assert `rst` for one cycle at cycle 10 of CONV → `out_valid` never rises for that operand; `in_ready` = 1 after the reset edge; the following conversion of 999 → 9,9,9 is correct.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the streaming binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_t;

  localparam int BCD_DIGIT_W = 4;

  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One double-dabble digit slice: add 3 when the digit is 5 or more, then shift left by one.
module bcd_digit_step
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  input  logic                   shift_in,
  output logic [BCD_DIGIT_W-1:0] digit_next,
  output logic                   shift_out
);

  logic [BCD_DIGIT_W-1:0] adj;

  always_comb begin
    adj        = (digit >= BCD_DIGIT_W'(5)) ? digit + BCD_DIGIT_W'(3) : digit;
    digit_next = {adj[BCD_DIGIT_W-2:0], shift_in};
    shift_out  = adj[BCD_DIGIT_W-1];
  end

endmodule

// File: rtl/bin_to_bcd_stream.sv
// Handshaked sequential binary-to-BCD converter, one input bit per clock,
// with optional signed input, sticky overflow and significant-digit count.
module bin_to_bcd_stream
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH  = 32,
  parameter int NUM_DIGITS = 10
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [BIN_WIDTH-1:0]                   in_data,
  input  logic                                   in_signed,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [NUM_DIGITS-1:0][BCD_DIGIT_W-1:0] bcd,
  output logic                                   neg,
  output logic                                   ovf,
  output logic [count_w(NUM_DIGITS)-1:0]         digit_count
);

  localparam int CNT_W = count_w(BIN_WIDTH);
  localparam int DC_W  = count_w(NUM_DIGITS);

  conv_state_t                           state;
  logic [BIN_WIDTH-1:0]                  shreg;
  logic [CNT_W-1:0]                      cnt;
  logic [BIN_WIDTH-1:0]                  mag;
  logic                                  in_neg;
  logic [NUM_DIGITS:0]                   carry;
  logic [NUM_DIGITS-1:0][BCD_DIGIT_W-1:0] bcd_step;

  // The most negative operand negates to itself, which read unsigned is the exact magnitude.
  always_comb begin
    in_neg = in_signed & in_data[BIN_WIDTH-1];
    mag    = in_neg ? -in_data : in_data;
  end

  assign carry[0] = shreg[BIN_WIDTH-1];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (bcd[g]),
      .shift_in   (carry[g]),
      .digit_next (bcd_step[g]),
      .shift_out  (carry[g+1])
    );
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      bcd       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= mag;
            neg   <= in_neg;
            bcd   <= '0;
            ovf   <= 1'b0;
            cnt   <= CNT_W'(BIN_WIDTH);
            state <= CONV;
          end
        end
        CONV: begin
          bcd   <= bcd_step;
          shreg <= shreg << 1;
          ovf   <= ovf | carry[NUM_DIGITS];
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    digit_count = DC_W'(1);
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i] != '0) digit_count = DC_W'(i + 1);
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// Randomised and directed bench for bin_to_bcd_stream; a 10-digit and a 3-digit
// instance run in lock-step and are checked against an arithmetic reference model.
module tb_bin_to_bcd_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_signed;
  logic        out_ready;

  logic        in_ready_a, out_valid_a, neg_a, ovf_a;
  logic [9:0][3:0] bcd_a;
  logic [3:0]  dc_a;
  logic        in_ready_b, out_valid_b, neg_b, ovf_b;
  logic [2:0][3:0] bcd_b;
  logic [1:0]  dc_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin_to_bcd_stream #(.BIN_WIDTH(32), .NUM_DIGITS(10)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid_a),
    .out_ready(out_ready), .bcd(bcd_a), .neg(neg_a), .ovf(ovf_a),
    .digit_count(dc_a)
  );

  bin_to_bcd_stream #(.BIN_WIDTH(32), .NUM_DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_signed(in_signed), .out_valid(out_valid_b),
    .out_ready(out_ready), .bcd(bcd_b), .neg(neg_b), .ovf(ovf_b),
    .digit_count(dc_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decimal expansion by repeated division; overflow is whatever magnitude remains.
  function automatic void model(input logic [31:0] d, input logic s, input int n,
                                output logic [63:0] ebcd, output logic eneg,
                                output logic eovf, output int edc);
    longint unsigned m;
    longint unsigned dig;
    eneg = s && d[31];
    m    = eneg ? (64'h1_0000_0000 - {32'b0, d}) : {32'b0, d};
    ebcd = '0;
    edc  = 1;
    for (int i = 0; i < n; i++) begin
      dig  = m % 10;
      m    = m / 10;
      ebcd = ebcd | (64'(dig) << (4 * i));
      if (dig != 0) edc = i + 1;
    end
    eovf = (m != 0);
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("excl_a", {63'b0, in_ready_a & out_valid_a}, 64'd0);
      check("excl_b", {63'b0, in_ready_b & out_valid_b}, 64'd0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {63'b0, in_ready_a}, 64'd1);
  endtask

  // One conversion; hold > 0 keeps out_ready low for that many DONE cycles
  // while offering junk data that must be ignored.
  task automatic run(input logic [31:0] d, input logic s, input int hold);
    logic [63:0] ea, eb;
    logic        na, nb, oa, ob;
    int          da, db;
    int          lat;
    model(d, s, 10, ea, na, oa, da);
    model(d, s, 3, eb, nb, ob, db);
    wait_ready();
    in_data   = d;
    in_signed = s;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_a && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'd32);
    check("valid_b", {63'b0, out_valid_b}, 64'd1);
    check("bcd_a", 64'(bcd_a), ea);
    check("neg_a", {63'b0, neg_a}, {63'b0, na});
    check("ovf_a", {63'b0, ovf_a}, {63'b0, oa});
    check("dc_a", 64'(dc_a), 64'(da));
    check("bcd_b", 64'(bcd_b), eb);
    check("ovf_b", {63'b0, ovf_b}, {63'b0, ob});
    check("dc_b", 64'(dc_b), 64'(db));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("hold_ready", {63'b0, in_ready_a}, 64'd0);
      check("hold_valid", {63'b0, out_valid_a}, 64'd1);
      check("hold_bcd", 64'(bcd_a), ea);
      check("hold_neg", {63'b0, neg_a}, {63'b0, na});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("consumed_valid", {63'b0, out_valid_a}, 64'd0);
    check("consumed_ready", {63'b0, in_ready_a}, 64'd1);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {63'b0, in_ready_a}, 64'd1);
    check("rst_valid", {63'b0, out_valid_a}, 64'd0);
    check("rst_bcd", 64'(bcd_a), 64'd0);
    check("rst_neg", {63'b0, neg_a}, 64'd0);
    check("rst_ovf", {63'b0, ovf_a}, 64'd0);
    check("rst_dc", 64'(dc_a), 64'd1);
    rst = 1'b0;

    run(32'd1234567890, 1'b0, 0);
    run(32'hFFFFFFFF, 1'b0, 0);
    run(32'h80000000, 1'b1, 0);
    run(32'hFFFFFFFF, 1'b1, 0);
    run(32'h00000000, 1'b0, 0);
    run(32'h00000000, 1'b1, 0);

    run(32'd4000000000, 1'b0, 5);
    run(32'd8675309, 1'b0, 0);

    // Reset in the middle of a conversion discards it.
    wait_ready();
    in_data   = 32'd123456;
    in_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", {63'b0, in_ready_a}, 64'd1);
    check("midrst_valid", {63'b0, out_valid_a}, 64'd0);
    check("midrst_bcd", 64'(bcd_a), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_a || out_valid_b) seen = 1;
    end
    check("midrst_never_valid", 64'(seen), 64'd0);
    run(32'd999, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      logic [31:0] d;
      d = $urandom;
      if (k % 3 == 0) d = d >> $urandom_range(31, 0);
      run(d, 1'($urandom_range(1, 0)), $urandom_range(3, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
